// File: rtl/mem_port_arbiter.sv
// Shares one memory block port between the icache refill path and the dcache refill/write-back path.
// Optional ARB_ROUND_ROBIN_EN: alternate grants on contention instead of fixed dcache priority.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 28,
    parameter int DATA_WIDTH = 128
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_mem_read,
    input  logic                  i_mem_write,
    input  logic [ADDR_WIDTH-1:0] i_mem_address,
    input  logic [DATA_WIDTH-1:0] i_mem_writedata,
    output logic [DATA_WIDTH-1:0] i_mem_readdata,
    output logic                  i_mem_busywait,
    input  logic                  d_mem_read,
    input  logic                  d_mem_write,
    input  logic [ADDR_WIDTH-1:0] d_mem_address,
    input  logic [DATA_WIDTH-1:0] d_mem_writedata,
    output logic [DATA_WIDTH-1:0] d_mem_readdata,
    output logic                  d_mem_busywait,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_writedata,
    input  logic [DATA_WIDTH-1:0] mem_readdata,
    input  logic                  mem_busywait
);

    // state   | meaning
    // IDLE    | no request driven, arbitrate on next edge
    // BUSY_I  | icache transaction in flight
    // BUSY_D  | dcache transaction in flight
    // DONE    | one cycle gap, winner's busywait released
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_BUSY_I = 2'd1;
    localparam logic [1:0] ST_BUSY_D = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    logic [1:0]            state_q, state_d;
    logic                  seen_busy_q, seen_busy_d;
    logic                  last_grant_q, last_grant_d;
    logic                  mem_read_q, mem_read_d;
    logic                  mem_write_q, mem_write_d;
    logic [ADDR_WIDTH-1:0] mem_address_q, mem_address_d;
    logic [DATA_WIDTH-1:0] mem_writedata_q, mem_writedata_d;
    logic [DATA_WIDTH-1:0] i_readdata_q, i_readdata_d;
    logic [DATA_WIDTH-1:0] d_readdata_q, d_readdata_d;
    logic                  req_i, req_d, win_d;

    assign req_i = i_mem_read | i_mem_write;
    assign req_d = d_mem_read | d_mem_write;

`ifdef ARB_ROUND_ROBIN_EN
    assign win_d = req_d & (~req_i | (last_grant_q == GRANT_I));
`else
    assign win_d = req_d;
`endif

    always_comb begin
        state_d         = state_q;
        seen_busy_d     = seen_busy_q;
        last_grant_d    = last_grant_q;
        mem_read_d      = mem_read_q;
        mem_write_d     = mem_write_q;
        mem_address_d   = mem_address_q;
        mem_writedata_d = mem_writedata_q;
        i_readdata_d    = i_readdata_q;
        d_readdata_d    = d_readdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req_i | req_d) begin
                    // A simultaneous read+write from one side is treated as a write.
                    if (win_d) begin
                        state_d         = ST_BUSY_D;
                        mem_write_d     = d_mem_write;
                        mem_read_d      = d_mem_read & ~d_mem_write;
                        mem_address_d   = d_mem_address;
                        mem_writedata_d = d_mem_writedata;
                    end else begin
                        state_d         = ST_BUSY_I;
                        mem_write_d     = i_mem_write;
                        mem_read_d      = i_mem_read & ~i_mem_write;
                        mem_address_d   = i_mem_address;
                        mem_writedata_d = i_mem_writedata;
                    end
                end
            end
            ST_BUSY_I, ST_BUSY_D: begin
                if (mem_busywait) begin
                    seen_busy_d = 1'b1;
                end else if (seen_busy_q) begin
                    if (mem_read_q) begin
                        if (state_q == ST_BUSY_D) d_readdata_d = mem_readdata;
                        else                      i_readdata_d = mem_readdata;
                    end
                    last_grant_d    = (state_q == ST_BUSY_D) ? GRANT_D : GRANT_I;
                    mem_read_d      = 1'b0;
                    mem_write_d     = 1'b0;
                    mem_address_d   = '0;
                    mem_writedata_d = '0;
                    seen_busy_d     = 1'b0;
                    state_d         = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q         <= ST_IDLE;
            seen_busy_q     <= 1'b0;
            last_grant_q    <= GRANT_I;
            mem_read_q      <= 1'b0;
            mem_write_q     <= 1'b0;
            mem_address_q   <= '0;
            mem_writedata_q <= '0;
            i_readdata_q    <= '0;
            d_readdata_q    <= '0;
        end else begin
            state_q         <= state_d;
            seen_busy_q     <= seen_busy_d;
            last_grant_q    <= last_grant_d;
            mem_read_q      <= mem_read_d;
            mem_write_q     <= mem_write_d;
            mem_address_q   <= mem_address_d;
            mem_writedata_q <= mem_writedata_d;
            i_readdata_q    <= i_readdata_d;
            d_readdata_q    <= d_readdata_d;
        end
    end

    assign mem_read       = mem_read_q;
    assign mem_write      = mem_write_q;
    assign mem_address    = mem_address_q;
    assign mem_writedata  = mem_writedata_q;
    assign i_mem_readdata = i_readdata_q;
    assign d_mem_readdata = d_readdata_q;

    // Only the requester just served sees its stall released, and only for the DONE cycle.
    assign i_mem_busywait = req_i & ~((state_q == ST_DONE) & (last_grant_q == GRANT_I));
    assign d_mem_busywait = req_d & ~((state_q == ST_DONE) & (last_grant_q == GRANT_D));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: transaction-level model plus directed scenarios.
// Honours ARB_ROUND_ROBIN_EN the same way as the design.
module tb_mem_port_arbiter;
    localparam int AW = 28;
    localparam int DW = 128;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          i_mem_read = 1'b0, i_mem_write = 1'b0;
    logic [AW-1:0] i_mem_address = '0;
    logic [DW-1:0] i_mem_writedata = '0;
    logic [DW-1:0] i_mem_readdata;
    logic          i_mem_busywait;
    logic          d_mem_read = 1'b0, d_mem_write = 1'b0;
    logic [AW-1:0] d_mem_address = '0;
    logic [DW-1:0] d_mem_writedata = '0;
    logic [DW-1:0] d_mem_readdata;
    logic          d_mem_busywait;
    logic          mem_read, mem_write;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_writedata;
    logic [DW-1:0] mem_readdata = '0;
    logic          mem_busywait = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    // memory model knobs
    int            mem_lat  = 4;
    int            mcnt     = 0;
    logic [DW-1:0] mem_base = '0;

    mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clock(clock), .reset(reset),
        .i_mem_read(i_mem_read), .i_mem_write(i_mem_write),
        .i_mem_address(i_mem_address), .i_mem_writedata(i_mem_writedata),
        .i_mem_readdata(i_mem_readdata), .i_mem_busywait(i_mem_busywait),
        .d_mem_read(d_mem_read), .d_mem_write(d_mem_write),
        .d_mem_address(d_mem_address), .d_mem_writedata(d_mem_writedata),
        .d_mem_readdata(d_mem_readdata), .d_mem_busywait(d_mem_busywait),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_writedata(mem_writedata),
        .mem_readdata(mem_readdata), .mem_busywait(mem_busywait)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction model: who owns the port, what it asked for, and the data each cache last received.
    int            m_mode;      // 0 free, 1 transfer in flight, 2 post-transfer gap
    logic          m_owner_d;
    logic          m_write;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    logic          m_seen;
    logic          m_last_d;
    logic [DW-1:0] m_ird, m_drd;

    task automatic model_reset();
        m_mode = 0; m_owner_d = 1'b0; m_write = 1'b0; m_addr = '0; m_data = '0;
        m_seen = 1'b0; m_last_d = 1'b0; m_ird = '0; m_drd = '0;
    endtask

    initial begin
        logic ri, rd, take_d;
        model_reset();
        forever begin
            @(posedge clock or negedge reset);
            if (!reset) begin
                model_reset();
            end else if (m_mode == 0) begin
                ri = i_mem_read | i_mem_write;
                rd = d_mem_read | d_mem_write;
                if (ri && rd) begin
`ifdef ARB_ROUND_ROBIN_EN
                    take_d = !m_last_d;
`else
                    take_d = 1'b1;
`endif
                end else begin
                    take_d = rd;
                end
                if (ri || rd) begin
                    m_owner_d = take_d;
                    m_write   = take_d ? d_mem_write : i_mem_write;
                    m_addr    = take_d ? d_mem_address : i_mem_address;
                    m_data    = take_d ? d_mem_writedata : i_mem_writedata;
                    m_seen    = 1'b0;
                    m_mode    = 1;
                end
            end else if (m_mode == 1) begin
                if (mem_busywait) begin
                    m_seen = 1'b1;
                end else if (m_seen) begin
                    if (!m_write) begin
                        if (m_owner_d) m_drd = mem_readdata;
                        else           m_ird = mem_readdata;
                    end
                    m_last_d = m_owner_d;
                    m_mode   = 2;
                end
            end else begin
                m_mode = 0;
            end
        end
    end

    // Per-cycle compare, then the memory responds to what it now sees on the port.
    initial begin
        forever begin
            @(negedge clock);
            check("mem_read",      {{(DW-1){1'b0}}, mem_read},  {{(DW-1){1'b0}}, (m_mode == 1) && !m_write});
            check("mem_write",     {{(DW-1){1'b0}}, mem_write}, {{(DW-1){1'b0}}, (m_mode == 1) && m_write});
            check("mem_address",   DW'(mem_address), (m_mode == 1) ? DW'(m_addr) : '0);
            check("mem_writedata", mem_writedata, (m_mode == 1) ? m_data : '0);
            check("i_busywait", {{(DW-1){1'b0}}, i_mem_busywait},
                  {{(DW-1){1'b0}}, (i_mem_read | i_mem_write) && !(m_mode == 2 && !m_last_d)});
            check("d_busywait", {{(DW-1){1'b0}}, d_mem_busywait},
                  {{(DW-1){1'b0}}, (d_mem_read | d_mem_write) && !(m_mode == 2 && m_last_d)});
            check("i_readdata", i_mem_readdata, m_ird);
            check("d_readdata", d_mem_readdata, m_drd);
            if (mem_read || mem_write) begin
                mem_readdata = mem_base ^ {4{4'h0, mem_address}};
                if (mcnt < mem_lat) begin
                    mem_busywait = 1'b1;
                    mcnt++;
                end else begin
                    mem_busywait = 1'b0;
                end
            end else begin
                mcnt = 0;
                mem_busywait = 1'b0;
            end
        end
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int step, ord_i, ord_d;

        // reset state
        tick(); tick();
        check("rst_mem_read",  {{(DW-1){1'b0}}, mem_read},  '0);
        check("rst_mem_write", {{(DW-1){1'b0}}, mem_write}, '0);
        check("rst_mem_addr",  DW'(mem_address), '0);
        check("rst_i_rdata",   i_mem_readdata, '0);
        check("rst_d_rdata",   d_mem_readdata, '0);
        reset = 1'b1;
        tick(); tick();

        // 1: single icache read, memory busy 4 cycles
        mem_lat  = 4;
        mem_base = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D ^ {4{32'h0000_0010}};
        i_mem_read = 1'b1; i_mem_address = 28'h0000010;
        @(negedge clock); k = 1;
        check("t1_mem_read_c1", {{(DW-1){1'b0}}, mem_read}, DW'(1));
        check("t1_addr_c1", DW'(mem_address), DW'(28'h0000010));
        while (i_mem_busywait && k < 50) begin @(negedge clock); k++; end
        check("t1_done_cycle", DW'(k), DW'(6));
        check("t1_i_rdata", i_mem_readdata, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D);
        #1 i_mem_read = 1'b0;
        tick(); tick();

        // 2: dcache write-back
        mem_base = '0;
        d_mem_write = 1'b1; d_mem_address = 28'h0000020;
        d_mem_writedata = 128'h11111111_11111111_11111111_11111111;
        @(negedge clock); k = 1;
        while (d_mem_busywait && k < 50) begin
            check("t2_mem_write", {{(DW-1){1'b0}}, mem_write}, DW'(1));
            check("t2_addr", DW'(mem_address), DW'(28'h0000020));
            check("t2_wdata", mem_writedata, 128'h11111111_11111111_11111111_11111111);
            @(negedge clock); k++;
        end
        check("t2_done_cycle", DW'(k), DW'(6));
        check("t2_done_no_write", {{(DW-1){1'b0}}, mem_write}, '0);
        check("t2_d_rdata_kept", d_mem_readdata, '0);
        #1 d_mem_write = 1'b0;
        tick(); tick();

        // 3: simultaneous icache 0x30 / dcache 0x40 reads
        mem_lat = 2;
        i_mem_read = 1'b1; i_mem_address = 28'h30;
        d_mem_read = 1'b1; d_mem_address = 28'h40;
        @(negedge clock);
`ifdef ARB_ROUND_ROBIN_EN
        check("t3_first_addr", DW'(mem_address), DW'(28'h30));
`else
        check("t3_first_addr", DW'(mem_address), DW'(28'h40));
`endif
        step = 0; ord_i = 0; ord_d = 0;
        for (int c = 0; c < 60 && (i_mem_read || d_mem_read); c++) begin
            if (i_mem_read && !i_mem_busywait) begin
                step++; ord_i = step; #1 i_mem_read = 1'b0;
            end else if (d_mem_read && !d_mem_busywait) begin
                step++; ord_d = step; #1 d_mem_read = 1'b0;
            end
            @(negedge clock);
        end
`ifdef ARB_ROUND_ROBIN_EN
        check("t3_order_i", DW'(ord_i), DW'(1));
        check("t3_order_d", DW'(ord_d), DW'(2));
`else
        check("t3_order_d", DW'(ord_d), DW'(1));
        check("t3_order_i", DW'(ord_i), DW'(2));
`endif
        check("t3_i_rdata", i_mem_readdata, {4{32'h0000_0030}});
        check("t3_d_rdata", d_mem_readdata, {4{32'h0000_0040}});
        tick(); tick();

        // 5: reset during the second BUSY_D cycle
        mem_lat = 3;
        d_mem_read = 1'b1; d_mem_address = 28'h60;
        @(negedge clock);
        @(negedge clock);
        #1 reset = 1'b0;
        #1;
        check("t5_rst_mem_read",  {{(DW-1){1'b0}}, mem_read},  '0);
        check("t5_rst_mem_write", {{(DW-1){1'b0}}, mem_write}, '0);
        check("t5_rst_d_busy",    {{(DW-1){1'b0}}, d_mem_busywait}, DW'(1));
        tick();
        reset = 1'b1;
        k = 0;
        @(negedge clock);
        while (d_mem_busywait && k < 50) begin @(negedge clock); k++; end
        check("t5_regrant_done", DW'(k < 50), DW'(1));
        check("t5_d_rdata", d_mem_readdata, {4{32'h0000_0060}});
        #1 d_mem_read = 1'b0;
        tick(); tick();

        // 6: read+write together -> write only; then back-to-back dcache read
        mem_lat = 1;
        d_mem_read = 1'b1; d_mem_write = 1'b1; d_mem_address = 28'h50;
        d_mem_writedata = 128'h55555555_55555555_55555555_55555555;
        @(negedge clock);
        check("t6_write_only_w", {{(DW-1){1'b0}}, mem_write}, DW'(1));
        check("t6_write_only_r", {{(DW-1){1'b0}}, mem_read},  '0);
        k = 0;
        while (d_mem_busywait && k < 50) begin @(negedge clock); k++; end
        check("t6_done_idle_port", {{(DW-2){1'b0}}, mem_read, mem_write}, '0);
        #1 d_mem_write = 1'b0; d_mem_address = 28'h58;
        @(negedge clock);
        check("t6_gap_idle_port", {{(DW-2){1'b0}}, mem_read, mem_write}, '0);
        check("t6_gap_busy", {{(DW-1){1'b0}}, d_mem_busywait}, DW'(1));
        @(negedge clock);
        check("t6_second_read", {{(DW-1){1'b0}}, mem_read}, DW'(1));
        check("t6_second_addr", DW'(mem_address), DW'(28'h58));
        k = 0;
        while (d_mem_busywait && k < 50) begin @(negedge clock); k++; end
        check("t6_second_done", DW'(k < 50), DW'(1));
        check("t6_d_rdata", d_mem_readdata, {4{32'h0000_0058}});
        #1 d_mem_read = 1'b0;
        tick(); tick(); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
